// File: rtl/ecg_data_active_seq.sv
`default_nettype none
// ============================================================================
// Module  : ecg_data_active_seq
// Brief   : Walks every (lead, component) slot of one ECG frame with
//           valid/ready handshaking and tags each slot with DataActive.
//           Optional ECG_DA_STATS_EN adds an active_count output.
// Revision: 1.0  initial release
// ============================================================================
module ecg_data_active_seq #(
   parameter int                N_CH      = 4,
   parameter int                N_COMP    = 4,
   parameter logic [N_COMP-1:0] SUBS_MASK = 4'b0110,
   localparam int               CH_W      = $clog2(N_CH),
   localparam int               CP_W      = (N_COMP > 1) ? $clog2(N_COMP) : 1
`ifdef ECG_DA_STATS_EN
   , localparam int             CNT_W     = $clog2(N_CH*N_COMP+1)
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        sub_sample_info,
   input  logic [N_COMP-1:0] component_skip,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [CH_W-1:0]   ecgidx,
   output logic [CP_W-1:0]   component_idx,
   output logic              DataActive,
   output logic              busy,
   output logic              done,
   output logic              mode_err
`ifdef ECG_DA_STATS_EN
   , output logic [CNT_W-1:0] active_count
`endif
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);
   localparam logic [CP_W-1:0] LAST_CP = CP_W'(N_COMP - 1);
   localparam logic [CH_W-1:0] HALF_CH = CH_W'(N_CH / 2);

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [CH_W-1:0]   r_lead;
   logic [CP_W-1:0]   r_comp;
   logic              r_da;
   logic [1:0]        r_mode;
   logic [N_COMP-1:0] r_skip;
   logic              r_mode_err;

   logic              w_start_ok;
   logic              w_accept;
   logic              w_last_slot;
   logic [CH_W-1:0]   w_lead_nxt;
   logic [CP_W-1:0]   w_comp_nxt;

   // Mode 3 shares the lead-0-only decode of mode 2 (only bit 1 is examined).
   function automatic logic da_calc(input logic [CH_W-1:0]   l,
                                    input logic [CP_W-1:0]   c,
                                    input logic [1:0]        m,
                                    input logic [N_COMP-1:0] sk);
      logic res;
      res = 1'b1;
      if (sk[c])
         res = 1'b0;
      else if (m[1])
         res = !((l != '0) && SUBS_MASK[c]);
      else if (m[0])
         res = !((l >= HALF_CH) && SUBS_MASK[c]);
      return res;
   endfunction

   assign w_start_ok  = (state == S_IDLE) && start;
   assign w_accept    = (state == S_RUN) && out_ready;
   assign w_last_slot = (r_lead == LAST_CH) && (r_comp == LAST_CP);

   always_comb begin
      w_lead_nxt = r_lead;
      w_comp_nxt = r_comp + 1'b1;
      if (r_comp == LAST_CP) begin
         w_comp_nxt = '0;
         w_lead_nxt = r_lead + 1'b1;
      end
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RUN;
         S_RUN:   if (w_accept && w_last_slot) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      out_valid = (state == S_RUN);
      busy      = (state != S_IDLE);
      done      = (state == S_DONE);
   end

   // Indices and DataActive move together so the presented slot is self-consistent.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_lead     <= '0;
         r_comp     <= '0;
         r_da       <= 1'b0;
         r_mode     <= 2'd0;
         r_skip     <= '0;
         r_mode_err <= 1'b0;
      end else if (w_start_ok) begin
         r_mode <= sub_sample_info;
         r_skip <= component_skip;
         r_lead <= '0;
         r_comp <= '0;
         r_da   <= da_calc('0, '0, sub_sample_info, component_skip);
         if (sub_sample_info == 2'd3)
            r_mode_err <= 1'b1;
      end else if (w_accept) begin
         if (w_last_slot) begin
            r_lead <= '0;
            r_comp <= '0;
            r_da   <= 1'b0;
         end else begin
            r_lead <= w_lead_nxt;
            r_comp <= w_comp_nxt;
            r_da   <= da_calc(w_lead_nxt, w_comp_nxt, r_mode, r_skip);
         end
      end
   end

   assign ecgidx        = r_lead;
   assign component_idx = r_comp;
   assign DataActive    = r_da;
   assign mode_err      = r_mode_err;

`ifdef ECG_DA_STATS_EN
   logic [CNT_W-1:0] r_active_count;

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_active_count <= '0;
      else if (w_start_ok)
         r_active_count <= '0;
      else if (w_accept && r_da)
         r_active_count <= r_active_count + 1'b1;
   end

   assign active_count = r_active_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ecg_data_active_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_ecg_data_active_seq
// Brief   : Directed scoreboard bench for ecg_data_active_seq (4 leads x 4 comps).
// Revision: 1.0  initial release
// ============================================================================
module tb_ecg_data_active_seq;

   localparam int         N_CH   = 4;
   localparam int         N_COMP = 4;
   localparam logic [3:0] SUBS   = 4'b0110;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       out_ready = 1'b0;
   logic [1:0] ssi = 2'd0;
   logic [3:0] skip = 4'd0;
   logic       out_valid;
   logic [1:0] ecgidx;
   logic [1:0] component_idx;
   logic       DataActive;
   logic       busy;
   logic       done;
   logic       mode_err;
`ifdef ECG_DA_STATS_EN
   logic [4:0] active_count;
`endif

   typedef struct packed {
      logic [1:0] l;
      logic [1:0] c;
      logic       da;
   } slot_t;

   slot_t sb[$];
   int    checks = 0;
   int    errors = 0;

   ecg_data_active_seq #(.N_CH(N_CH), .N_COMP(N_COMP), .SUBS_MASK(SUBS)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .sub_sample_info (ssi),
      .component_skip  (skip),
      .out_ready       (out_ready),
      .out_valid       (out_valid),
      .ecgidx          (ecgidx),
      .component_idx   (component_idx),
      .DataActive      (DataActive),
      .busy            (busy),
      .done            (done),
      .mode_err        (mode_err)
`ifdef ECG_DA_STATS_EN
      , .active_count  (active_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_da(input int l, input int c, input logic [1:0] m, input logic [3:0] sk);
      logic s;
      s = SUBS[c];
      if (sk[c]) return 1'b0;
      case (m)
         2'd0:    return 1'b1;
         2'd1:    return !((l >= N_CH/2) && s);
         default: return !((l != 0) && s);
      endcase
   endfunction

   task automatic push_frame(input logic [1:0] m, input logic [3:0] sk);
      slot_t e;
      sb.delete();
      for (int l = 0; l < N_CH; l++)
         for (int c = 0; c < N_COMP; c++) begin
            e.l  = 2'(l);
            e.c  = 2'(c);
            e.da = model_da(l, c, m, sk);
            sb.push_back(e);
         end
   endtask

   task automatic run_frame(input logic [1:0] m, input logic [3:0] sk, input bit toggle,
                            input int exp_active, input int exp_done_n,
                            input bit restart_mid, input bit start_on_done);
      int    n;
      int    accepts;
      int    act;
      bit    fin;
      slot_t e;
      push_frame((m == 2'd3) ? 2'd2 : m, sk);
      start = 1'b1; ssi = m; skip = sk; out_ready = 1'b1;
      step();
      start = 1'b0; ssi = ~m; skip = ~sk;
      n = 1; accepts = 0; act = 0; fin = 0;
      while (!fin && n < 200) begin
         if (done) begin
            chk("done_queue_empty", 32'(sb.size()), 32'd0);
            chk("done_valid_low", 32'(out_valid), 32'd0);
            if (exp_done_n > 0) chk("done_cycle", 32'(n), 32'(exp_done_n));
            fin = 1;
         end else begin
            chk("valid", 32'(out_valid), 32'd1);
            chk("busy_run", 32'(busy), 32'd1);
            if (sb.size() > 0) begin
               e = sb[0];
               chk("lead", 32'(ecgidx), 32'(e.l));
               chk("comp", 32'(component_idx), 32'(e.c));
               chk("data_active", 32'(DataActive), 32'(e.da));
            end else
               chk("extra_slot", 32'(out_valid), 32'd0);
            start = (restart_mid && n == 3);
            if (restart_mid && n == 3) begin ssi = 2'd0; skip = 4'hF; end
            out_ready = toggle ? (n % 2 == 1) : 1'b1;
            if (out_ready && out_valid && sb.size() > 0) begin
               accepts++;
               act += int'(DataActive);
               void'(sb.pop_front());
            end
            step();
            n++;
         end
      end
      if (!fin) chk("done_timeout", 32'(done), 32'd1);
      chk("accepts", 32'(accepts), 32'd16);
      chk("active_slots", 32'(act), 32'(exp_active));
`ifdef ECG_DA_STATS_EN
      chk("active_count", 32'(active_count), 32'(exp_active));
`endif
      start = start_on_done; ssi = 2'd0; skip = 4'd0;
      step();
      start = 1'b0;
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("idle_after_done", 32'(busy), 32'd0);
      chk("idle_valid", 32'(out_valid), 32'd0);
      chk("idle_da", 32'(DataActive), 32'd0);
      step();
      chk("start_at_done_ignored", 32'(busy), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      step();
      step();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_idx", 32'({ecgidx, component_idx}), 32'd0);
      chk("rst_da", 32'(DataActive), 32'd0);
      chk("rst_mode_err", 32'(mode_err), 32'd0);
      rst_n = 1'b1;
      step();

      run_frame(2'd0, 4'b0000, 1'b0, 16, 17, 1'b0, 1'b1);
      run_frame(2'd1, 4'b0000, 1'b0, 12, 17, 1'b0, 1'b0);
      run_frame(2'd2, 4'b1000, 1'b0, 6, 17, 1'b0, 1'b0);
      run_frame(2'd0, 4'b0000, 1'b1, 16, 32, 1'b0, 1'b0);
      chk("mode_err_clear", 32'(mode_err), 32'd0);
      run_frame(2'd3, 4'b0000, 1'b0, 10, 17, 1'b1, 1'b0);
      chk("mode_err_set", 32'(mode_err), 32'd1);

      // Abort mid-walk with reset at slot (1,2).
      push_frame(2'd0, 4'd0);
      start = 1'b1; ssi = 2'd0; skip = 4'd0; out_ready = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (ecgidx == 2'd1 && component_idx == 2'd2) break;
         step();
      end
      chk("abort_lead", 32'(ecgidx), 32'd1);
      chk("abort_comp", 32'(component_idx), 32'd2);
      rst_n = 1'b0;
      step();
      chk("abort_valid", 32'(out_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_idx", 32'({ecgidx, component_idx}), 32'd0);
      chk("abort_mode_err", 32'(mode_err), 32'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("abort_no_done", 32'(done), 32'd0);
      end
      run_frame(2'd0, 4'b0000, 1'b0, 16, 17, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
